// File: rtl/vedic_seq_mult.sv
// Iterative WIDTH x WIDTH unsigned multiplier: one 2x2 Urdhva-Tiryagbhyam digit product per
// cycle, shifted into a 2*WIDTH accumulator, with valid/ready handshakes on both sides.
module vedic_seq_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned AccW = 2 * WIDTH;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [AccW-1:0]   acc_q, acc_d, product_q, product_d;
  logic [IdxW-1:0]   i_q, i_d, j_q, j_d;

  logic [1:0]        a_dig, b_dig;
  logic [3:0]        pp;
  logic [IdxW+1:0]   shamt;
  logic [AccW-1:0]   pp_sh;

  // 2x2 digit product from AND gates and two half adders.
  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic t0, t1, c, hh;
    t0 = x[1] & y[0];
    t1 = x[0] & y[1];
    c  = t0 & t1;
    hh = x[1] & y[1];
    return {hh & c, hh ^ c, t0 ^ t1, x[0] & y[0]};
  endfunction

  assign a_dig   = a_q[{i_q, 1'b0} +: 2];
  assign b_dig   = b_q[{j_q, 1'b0} +: 2];
  assign pp      = vedic2x2(a_dig, b_dig);
  assign shamt   = {1'b0, i_q, 1'b0} + {1'b0, j_q, 1'b0};
  assign pp_sh   = AccW'(pp) << shamt;
  assign product = product_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    i_d       = i_q;
    j_d       = j_q;
    product_d = product_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        busy  = 1'b1;
        acc_d = acc_q + pp_sh;
        if (j_q == LastIdx) begin
          j_d = '0;
          if (i_q == LastIdx) begin
            i_d       = '0;
            product_d = acc_q + pp_sh;
            state_d   = StDone;
          end else begin
            i_d = i_q + IdxW'(1);
          end
        end else begin
          j_d = j_q + IdxW'(1);
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Self-checking bench for vedic_seq_mult: directed table, corner sequences and random
// operands against a plain a*b reference.
module tb_vedic_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_vec;
  int n_bad;
  int cyc;
  int last_accept;
  logic [15:0] prev_prod;

  vedic_seq_mult #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          stall;
    bit          noise;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input int stall,
                        input bit noise, input logic [15:0] exp, input string tag);
    int cnt;
    in_valid = 1'b1;
    a        = ta;
    b        = tbv;
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    if (last_accept >= 0) chk({tag, "_ii_ge_18"}, 32'((cyc + 1 - last_accept) >= 18), 32'd1);
    @(posedge clk); #1;
    last_accept = cyc;
    in_valid    = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_in_ready_calc"}, 32'(in_ready), 32'd0);
      chk({tag, "_product_hold"}, 32'(product), 32'(prev_prod));
      if (noise) begin
        in_valid = 1'($urandom);
        a        = 8'hFF;
        b        = 8'hFF;
      end
      @(posedge clk); #1;
      cnt++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(cnt), 32'd16);
    chk({tag, "_product"}, 32'(product), 32'(exp));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_stall_product"}, 32'(product), 32'(exp));
      chk({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_product_kept"}, 32'(product), 32'(exp));
    prev_prod = exp;
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] rexp;
    n_vec       = 0;
    n_bad       = 0;
    last_accept = -1;
    prev_prod   = 16'h0000;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = 8'h00;
    b           = 8'h00;
    rst_n       = 1'b0;

    vecs[0] = '{a: 8'hFF, b: 8'hFF, stall: 0,  noise: 1'b0, exp: 16'hFE01, name: "max"};
    vecs[1] = '{a: 8'h00, b: 8'hA7, stall: 0,  noise: 1'b0, exp: 16'h0000, name: "zero"};
    vecs[2] = '{a: 8'h01, b: 8'hA7, stall: 0,  noise: 1'b0, exp: 16'h00A7, name: "ident"};
    vecs[3] = '{a: 8'h0D, b: 8'h0B, stall: 10, noise: 1'b0, exp: 16'h008F, name: "bkpress"};
    vecs[4] = '{a: 8'h12, b: 8'h34, stall: 2,  noise: 1'b1, exp: 16'h03A8, name: "ignore"};
    vecs[5] = '{a: 8'h03, b: 8'h03, stall: 1,  noise: 1'b0, exp: 16'h0009, name: "threes"};

    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].stall, vecs[k].noise, vecs[k].exp, vecs[k].name);
    end

    // Asynchronous reset in the seventh CALC cycle.
    in_valid = 1'b1;
    a        = 8'hC3;
    b        = 8'h5A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    prev_prod   = 16'h0000;
    last_accept = -1;
    run_op(8'h02, 8'h03, 0, 1'b0, 16'h0006, "post_rst");

    for (int n = 0; n < 200; n++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rexp = 16'(ra) * 16'(rb);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(ra, rb, int'($urandom_range(0, 4)), 1'b0, rexp, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
